// File: rtl/udma_traffic_chk_tx_if.sv
// Streaming handshake bundle between a uDMA TX channel and its sink.
// Signals: data, valid (source -> sink), ready (sink -> source).
interface udma_traffic_chk_tx_if #(
   parameter int DATA_WIDTH = 32
);
   logic [DATA_WIDTH-1:0] data;
   logic                  valid;
   logic                  ready;

   modport master (
      output data,
      output valid,
      input  ready
   );

   modport slave (
      input  data,
      input  valid,
      output ready
   );
endinterface

// File: rtl/udma_traffic_chk_tx.sv
// Self-checking sink for a uDMA TX channel: compares each accepted word
// against initial_value + k and reports error count, first-error index,
// completion.
// Ports: clk_i, rstn_i (async, active-low), cfg_setup_i ([0] en,
// [3:1] stall, [15:8] target, [31:16] initial), tx (slave: data/valid
// in, ready out), busy_o, done_o, err_o, err_cnt_o, first_err_idx_o,
// words_o.
module udma_traffic_chk_tx #(
   parameter int DATA_WIDTH = 32,
   parameter int CNT_WIDTH  = 8,
   parameter int ERR_WIDTH  = 16
) (
   input  logic                 clk_i,
   input  logic                 rstn_i,
   input  logic [31:0]          cfg_setup_i,
   udma_traffic_chk_tx_if.slave tx,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 err_o,
   output logic [ERR_WIDTH-1:0] err_cnt_o,
   output logic [CNT_WIDTH-1:0] first_err_idx_o,
   output logic [CNT_WIDTH-1:0] words_o
);

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      CHECK      = 2'd1,
      WAIT_CLEAR = 2'd2
   } state_t;

   state_t                state;
   logic [2:0]            stall;
   logic [2:0]            stall_cnt;
   logic [CNT_WIDTH-1:0]  target;
   logic [CNT_WIDTH-1:0]  cfg_target;
   logic [CNT_WIDTH-1:0]  words_nxt;
   logic [DATA_WIDTH-1:0] exp_data;
   logic                  cfg_en;
   logic                  hs;
   logic                  unused_cfg;

   assign cfg_en     = cfg_setup_i[0];
   assign cfg_target = CNT_WIDTH'(cfg_setup_i[15:8]);
   assign unused_cfg = ^cfg_setup_i[7:4];

   // Ready comes from registers only so the source may wait on it.
   assign tx.ready = (state == CHECK) && (stall_cnt == 3'd0);
   assign hs       = tx.valid & tx.ready;
   assign busy_o   = (state == CHECK);
   assign done_o   = (state == WAIT_CLEAR);
   assign words_nxt = words_o + CNT_WIDTH'(1);

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         state           <= IDLE;
         stall           <= '0;
         stall_cnt       <= '0;
         target          <= '0;
         exp_data        <= '0;
         words_o         <= '0;
         err_cnt_o       <= '0;
         err_o           <= 1'b0;
         first_err_idx_o <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (cfg_en) begin
                  stall           <= cfg_setup_i[3:1];
                  target          <= cfg_target;
                  exp_data        <= DATA_WIDTH'(cfg_setup_i[31:16]);
                  words_o         <= '0;
                  err_cnt_o       <= '0;
                  err_o           <= 1'b0;
                  first_err_idx_o <= '0;
                  stall_cnt       <= '0;
                  state <= (cfg_target == '0) ? WAIT_CLEAR : CHECK;
               end
            end
            CHECK: begin
               if (hs) begin
                  if (tx.data != exp_data) begin
                     if (err_cnt_o != '1)
                        err_cnt_o <= err_cnt_o + ERR_WIDTH'(1);
                     if (!err_o)
                        first_err_idx_o <= words_o;
                     err_o <= 1'b1;
                  end
                  exp_data  <= exp_data + DATA_WIDTH'(1);
                  words_o   <= words_nxt;
                  stall_cnt <= stall;
               end else if (stall_cnt != 3'd0) begin
                  stall_cnt <= stall_cnt - 3'd1;
               end
               // Abort outranks completion; the final word is still counted.
               if (!cfg_en)
                  state <= IDLE;
               else if (hs && (words_nxt == target))
                  state <= WAIT_CLEAR;
            end
            WAIT_CLEAR: begin
               if (!cfg_en)
                  state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_udma_traffic_chk_tx.sv
// Scoreboard bench for udma_traffic_chk_tx, with a second ERR_WIDTH=4
// instance fed the same stream to exercise counter saturation.
module tb_udma_traffic_chk_tx;
   localparam int DW = 32;

   typedef logic [DW-1:0] word_q_t[$];
   typedef struct {
      int errs;
      int first;
      int words;
   } res_t;

   logic        clk  = 1'b0;
   logic        rstn = 1'b1;
   logic [31:0] cfg  = '0;

   logic        busy, done, err;
   logic [15:0] err_cnt;
   logic [7:0]  first_idx, words;
   logic        busy4, done4, err4;
   logic [3:0]  err_cnt4;
   logic [7:0]  first4, words4;

   int   n_cmp = 0;
   int   n_bad = 0;
   res_t sbq[$];

   udma_traffic_chk_tx_if #(.DATA_WIDTH(DW)) tx ();
   udma_traffic_chk_tx_if #(.DATA_WIDTH(DW)) tx4 ();

   assign tx4.data  = tx.data;
   assign tx4.valid = tx.valid;

   always #5 clk = ~clk;

   udma_traffic_chk_tx #(
      .DATA_WIDTH(DW), .CNT_WIDTH(8), .ERR_WIDTH(16)
   ) dut (
      .clk_i(clk), .rstn_i(rstn), .cfg_setup_i(cfg), .tx(tx),
      .busy_o(busy), .done_o(done), .err_o(err), .err_cnt_o(err_cnt),
      .first_err_idx_o(first_idx), .words_o(words)
   );

   udma_traffic_chk_tx #(
      .DATA_WIDTH(DW), .CNT_WIDTH(8), .ERR_WIDTH(4)
   ) dut4 (
      .clk_i(clk), .rstn_i(rstn), .cfg_setup_i(cfg), .tx(tx4),
      .busy_o(busy4), .done_o(done4), .err_o(err4), .err_cnt_o(err_cnt4),
      .first_err_idx_o(first4), .words_o(words4)
   );

   task automatic check(input string name, input logic [63:0] act,
                        input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: each completed run pops one expected result.
   logic done_q = 1'b0;
   always @(negedge clk) begin
      res_t r;
      if (rstn && done && !done_q) begin
         if (sbq.size() == 0) begin
            check("sb_unexpected_done", 64'd1, 64'd0);
         end else begin
            r = sbq.pop_front();
            check("sb_err_cnt", 64'(err_cnt), 64'(r.errs));
            check("sb_err", 64'(err), 64'(r.errs != 0));
            check("sb_first_idx", 64'(first_idx), 64'(r.first));
            check("sb_words", 64'(words), 64'(r.words));
            check("sb_err_cnt4", 64'(err_cnt4),
                  64'((r.errs > 15) ? 15 : r.errs));
            check("sb_done4", 64'(done4), 64'd1);
         end
      end
      done_q = done;
   end

   // Drives one run from a planned word list; ready timing is predicted
   // from the stall rule: after an accepted word, ready stays low for
   // exactly `stall` cycles, independent of valid.
   task automatic run_plan(input int init, input int stall,
                           input word_q_t plan, input int vld_pct);
      res_t r;
      int   target, k, since, cyc, budget;
      logic vexp, rexp;
      target  = plan.size();
      r.errs  = 0;
      r.first = 0;
      r.words = target;
      for (int i = 0; i < target; i++) begin
         if (plan[i] != DW'(init + i)) begin
            if (r.errs == 0) r.first = i;
            r.errs++;
         end
      end
      sbq.push_back(r);
      @(negedge clk);
      tx.valid = 1'b0;
      cfg = {init[15:0], target[7:0], 4'b0, stall[2:0], 1'b1};
      @(posedge clk);
      @(negedge clk);
      check("clr_words", 64'(words), 64'd0);
      check("clr_err_cnt", 64'(err_cnt), 64'd0);
      check("clr_err", 64'(err), 64'd0);
      check("start_busy", 64'(busy), 64'(target != 0));
      k      = 0;
      since  = stall;
      cyc    = 0;
      budget = (target + 1) * (stall + 1) * 8 + 20;
      while (k < target) begin
         if (cyc >= budget) begin
            check("run_timeout", 64'd0, 64'd1);
            break;
         end
         cyc++;
         rexp = (since >= stall);
         check("ready", 64'(tx.ready), 64'(rexp));
         vexp = ($urandom_range(99) < vld_pct);
         tx.valid = vexp;
         tx.data  = vexp ? plan[k] : DW'($urandom);
         @(posedge clk);
         if (vexp && rexp) begin
            k++;
            since = 0;
         end else begin
            since++;
         end
         @(negedge clk);
      end
      tx.valid = 1'b0;
      check("end_done", 64'(done), 64'd1);
      check("end_busy", 64'(busy), 64'd0);
      check("end_ready", 64'(tx.ready), 64'd0);
      repeat (2) @(negedge clk);
      check("wait_ready", 64'(tx.ready), 64'd0);
      check("wait_done", 64'(done), 64'd1);
      cfg[0] = 1'b0;
      @(negedge clk);
      check("idle_done", 64'(done), 64'd0);
      check("idle_words", 64'(words), 64'(target));
   endtask

   task automatic run(input int init, input int target, input int stall,
                      input int bad_pct, input int vld_pct);
      word_q_t          plan;
      logic [DW-1:0]    w;
      for (int i = 0; i < target; i++) begin
         w = DW'(init + i);
         if ($urandom_range(99) < bad_pct)
            w = w ^ (DW'(1) << $urandom_range(DW - 1));
         plan.push_back(w);
      end
      run_plan(init, stall, plan, vld_pct);
   endtask

   initial begin
      word_q_t p2;
      tx.valid = 1'b0;
      tx.data  = '0;
      #2 rstn = 1'b0;
      #1;
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_err", 64'(err), 64'd0);
      check("rst_err_cnt", 64'(err_cnt), 64'd0);
      check("rst_first", 64'(first_idx), 64'd0);
      check("rst_words", 64'(words), 64'd0);
      check("rst_ready", 64'(tx.ready), 64'd0);
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      check("idle_ready", 64'(tx.ready), 64'd0);

      // Clean run, one word per cycle.
      run(32'h0010, 4, 0, 0, 100);

      // Two bad words at indices 2 and 4.
      p2 = {32'h100, 32'h101, 32'hDEAD, 32'h103, 32'h0};
      run_plan(32'h0100, 0, p2, 100);

      // Stall spacing with valid held high.
      run(32'h0040, 3, 2, 0, 100);

      // Empty run goes straight to done.
      run(32'h0077, 0, 0, 0, 100);

      // Abort after three words.
      @(negedge clk);
      cfg = {16'h0020, 8'd8, 4'b0, 3'd0, 1'b1};
      @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         tx.valid = 1'b1;
         tx.data  = DW'(32'h20 + i);
         @(negedge clk);
      end
      tx.valid = 1'b0;
      cfg[0]   = 1'b0;
      @(negedge clk);
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_ready", 64'(tx.ready), 64'd0);
      check("abort_done", 64'(done), 64'd0);
      check("abort_words", 64'(words), 64'd3);

      // Abort coinciding with an accepted (bad) word.
      cfg[0] = 1'b1;
      @(negedge clk);
      check("reen_words", 64'(words), 64'd0);
      tx.valid = 1'b1;
      tx.data  = 32'h20;
      @(negedge clk);
      tx.data = 32'h99;
      cfg[0]  = 1'b0;
      @(negedge clk);
      tx.valid = 1'b0;
      check("abort_hs_words", 64'(words), 64'd2);
      check("abort_hs_err_cnt", 64'(err_cnt), 64'd1);
      check("abort_hs_first", 64'(first_idx), 64'd1);
      check("abort_hs_busy", 64'(busy), 64'd0);

      // Randomized runs.
      repeat (12)
         run(int'($urandom_range(0, 65535)), int'($urandom_range(1, 40)),
             int'($urandom_range(0, 7)), int'($urandom_range(0, 50)),
             int'($urandom_range(30, 100)));

      // All-bad maximum-length run saturates the 4-bit counter.
      run(int'($urandom_range(0, 65535)), 255, 0, 100, 100);

      // Asynchronous reset in the middle of a run.
      @(negedge clk);
      cfg = {16'h0500, 8'd50, 4'b0, 3'd0, 1'b1};
      @(posedge clk);
      @(negedge clk);
      tx.valid = 1'b1;
      tx.data  = 32'h0;
      repeat (4) @(negedge clk);
      check("pre_rst_err_cnt", 64'(err_cnt), 64'd4);
      check("pre_rst_busy", 64'(busy), 64'd1);
      #2 rstn = 1'b0;
      #1;
      check("arst_ready", 64'(tx.ready), 64'd0);
      check("arst_busy", 64'(busy), 64'd0);
      check("arst_err", 64'(err), 64'd0);
      check("arst_err_cnt", 64'(err_cnt), 64'd0);
      check("arst_words", 64'(words), 64'd0);
      check("arst_err_cnt4", 64'(err_cnt4), 64'd0);
      tx.valid = 1'b0;
      cfg      = '0;
      @(negedge clk);
      rstn = 1'b1;
      @(negedge clk);
      check("post_rst_ready", 64'(tx.ready), 64'd0);

      check("sb_drain", 64'(sbq.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule
